// File: rtl/compare_qualifier_if.sv
// Bus between a comparator front end and the compare_qualifier stage:
// raw relation flags in, debounced state, pulses and entry counters out.
interface compare_qualifier_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             lesser;
    logic             equal;
    logic             greater;
    logic             clear;
    logic [1:0]       state;
    logic             state_valid;
    logic             change_pulse;
    logic [CNT_W-1:0] cnt_lt;
    logic [CNT_W-1:0] cnt_eq;
    logic [CNT_W-1:0] cnt_gt;
    logic             err_pulse;
    logic             err_sticky;

    modport master (
        output in_valid, lesser, equal, greater, clear,
        input  state, state_valid, change_pulse, cnt_lt, cnt_eq, cnt_gt,
               err_pulse, err_sticky
    );

    modport slave (
        input  in_valid, lesser, equal, greater, clear,
        output state, state_valid, change_pulse, cnt_lt, cnt_eq, cnt_gt,
               err_pulse, err_sticky
    );
endinterface

// File: rtl/compare_qualifier.sv
// Debounces comparator lesser/equal/greater flags into a LOW/MATCH/HIGH state
// after HOLD identical valid samples; counts entries and flags illegal samples.
module compare_qualifier #(
    parameter int unsigned HOLD  = 4,
    parameter int unsigned CNT_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    compare_qualifier_if.slave bus
);
    localparam int unsigned RUN_W = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_LOW     = 2'b01,
        ST_MATCH   = 2'b10,
        ST_HIGH    = 2'b11
    } rel_e;

    rel_e             state_q, state_d;
    rel_e             cand_q, cand_d;
    rel_e             cls;
    logic [RUN_W-1:0] run_q, run_d;
    logic             state_valid_q, state_valid_d;
    logic             change_q, change_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] cnt_lt_q, cnt_lt_d;
    logic [CNT_W-1:0] cnt_eq_q, cnt_eq_d;
    logic [CNT_W-1:0] cnt_gt_q, cnt_gt_d;
    logic             legal;

    // Sample classification: legal only when exactly one flag is set
    always_comb begin
        cls   = ST_UNKNOWN;
        legal = (2'(bus.lesser) + 2'(bus.equal) + 2'(bus.greater)) == 2'd1;
        if (bus.lesser)       cls = ST_LOW;
        else if (bus.equal)   cls = ST_MATCH;
        else if (bus.greater) cls = ST_HIGH;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_UNKNOWN;
            cand_q        <= ST_UNKNOWN;
            run_q         <= '0;
            state_valid_q <= 1'b0;
            change_q      <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_sticky_q  <= 1'b0;
            cnt_lt_q      <= '0;
            cnt_eq_q      <= '0;
            cnt_gt_q      <= '0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            run_q         <= run_d;
            state_valid_q <= state_valid_d;
            change_q      <= change_d;
            err_pulse_q   <= err_pulse_d;
            err_sticky_q  <= err_sticky_d;
            cnt_lt_q      <= cnt_lt_d;
            cnt_eq_q      <= cnt_eq_d;
            cnt_gt_q      <= cnt_gt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        run_d        = run_q;
        change_d     = 1'b0;
        err_pulse_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        cnt_lt_d     = cnt_lt_q;
        cnt_eq_d     = cnt_eq_q;
        cnt_gt_d     = cnt_gt_q;

        if (bus.in_valid) begin
            if (!legal) begin
                err_pulse_d  = 1'b1;
                err_sticky_d = 1'b1;
                run_d        = '0;
                cand_d       = ST_UNKNOWN;
            end else begin
                if (cls == cand_q) begin
                    if (run_q != RUN_W'(HOLD)) run_d = run_q + RUN_W'(1);
                end else begin
                    cand_d = cls;
                    run_d  = RUN_W'(1);
                end
                // Qualification into a different state; re-qualifying is silent
                if (run_d == RUN_W'(HOLD) && cls != state_q) begin
                    state_d  = cls;
                    change_d = 1'b1;
                    unique case (cls)
                        ST_LOW:   if (cnt_lt_q != '1) cnt_lt_d = cnt_lt_q + CNT_W'(1);
                        ST_MATCH: if (cnt_eq_q != '1) cnt_eq_d = cnt_eq_q + CNT_W'(1);
                        ST_HIGH:  if (cnt_gt_q != '1) cnt_gt_d = cnt_gt_q + CNT_W'(1);
                        default:  ;
                    endcase
                end
            end
        end

        // Clear wins over any same-cycle increment or error set
        if (bus.clear) begin
            cnt_lt_d     = '0;
            cnt_eq_d     = '0;
            cnt_gt_d     = '0;
            err_sticky_d = 1'b0;
        end

        state_valid_d = (state_d != ST_UNKNOWN);
    end

    assign bus.state        = state_q;
    assign bus.state_valid  = state_valid_q;
    assign bus.change_pulse = change_q;
    assign bus.cnt_lt       = cnt_lt_q;
    assign bus.cnt_eq       = cnt_eq_q;
    assign bus.cnt_gt       = cnt_gt_q;
    assign bus.err_pulse    = err_pulse_q;
    assign bus.err_sticky   = err_sticky_q;
endmodule

// File: tb/tb_compare_qualifier.sv
// Directed bench for compare_qualifier: one HOLD=4/CNT_W=16 instance and one
// HOLD=4/CNT_W=2 instance driven by the same stimulus.
module tb_compare_qualifier;
    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, lesser, equal, greater, clear;

    int checks = 0;
    int errors = 0;

    compare_qualifier_if #(.CNT_W(16)) bus_a ();
    compare_qualifier_if #(.CNT_W(2))  bus_b ();

    assign bus_a.in_valid = in_valid;
    assign bus_a.lesser   = lesser;
    assign bus_a.equal    = equal;
    assign bus_a.greater  = greater;
    assign bus_a.clear    = clear;
    assign bus_b.in_valid = in_valid;
    assign bus_b.lesser   = lesser;
    assign bus_b.equal    = equal;
    assign bus_b.greater  = greater;
    assign bus_b.clear    = clear;

    compare_qualifier #(.HOLD(4), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    compare_qualifier #(.HOLD(4), .CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1ns after the edge
    task automatic step(input logic v, input logic l, input logic e, input logic g, input logic c);
        in_valid = v; lesser = l; equal = e; greater = g; clear = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0; lesser = 1'b0; equal = 1'b0; greater = 1'b0; clear = 1'b0;
    endtask

    task automatic samples(input int n, input logic l, input logic e, input logic g);
        for (int i = 0; i < n; i++) step(1'b1, l, e, g, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; lesser = 1'b0; equal = 1'b0; greater = 1'b0; clear = 1'b0;
        do_reset();
        check("rst_state",  32'(bus_a.state), 32'd0);
        check("rst_svalid", 32'(bus_a.state_valid), 32'd0);
        check("rst_change", 32'(bus_a.change_pulse), 32'd0);
        check("rst_cnts",   32'(bus_a.cnt_lt) | 32'(bus_a.cnt_eq) | 32'(bus_a.cnt_gt), 32'd0);
        check("rst_err",    32'({bus_a.err_pulse, bus_a.err_sticky}), 32'd0);

        // 1: four lesser samples qualify LOW
        samples(3, 1'b1, 1'b0, 1'b0);
        check("t1_pre_state", 32'(bus_a.state), 32'd0);
        samples(1, 1'b1, 1'b0, 1'b0);
        check("t1_state",  32'(bus_a.state), 32'd1);
        check("t1_svalid", 32'(bus_a.state_valid), 32'd1);
        check("t1_change", 32'(bus_a.change_pulse), 32'd1);
        check("t1_cnt_lt", 32'(bus_a.cnt_lt), 32'd1);
        idle(1);
        check("t1_change_off", 32'(bus_a.change_pulse), 32'd0);
        // Re-qualifying LOW is silent
        samples(4, 1'b1, 1'b0, 1'b0);
        check("t1_requal_change", 32'(bus_a.change_pulse), 32'd0);
        check("t1_requal_cnt",    32'(bus_a.cnt_lt), 32'd1);

        // 2: a greater sample breaks the equal run
        samples(3, 1'b0, 1'b1, 1'b0);
        samples(1, 1'b0, 1'b0, 1'b1);
        samples(3, 1'b0, 1'b1, 1'b0);
        check("t2_pre_state", 32'(bus_a.state), 32'd1);
        samples(1, 1'b0, 1'b1, 1'b0);
        check("t2_state",  32'(bus_a.state), 32'd2);
        check("t2_change", 32'(bus_a.change_pulse), 32'd1);
        check("t2_cnt_eq", 32'(bus_a.cnt_eq), 32'd1);
        check("t2_cnt_gt", 32'(bus_a.cnt_gt), 32'd0);

        // 3: back to LOW, then equal samples separated by idle gaps
        samples(4, 1'b1, 1'b0, 1'b0);
        check("t3_low", 32'(bus_a.state), 32'd1);
        check("t3_cnt_lt", 32'(bus_a.cnt_lt), 32'd2);
        for (int i = 0; i < 3; i++) begin
            samples(1, 1'b0, 1'b1, 1'b0);
            idle(5);
        end
        check("t3_pre_state", 32'(bus_a.state), 32'd1);
        samples(1, 1'b0, 1'b1, 1'b0);
        check("t3_state",  32'(bus_a.state), 32'd2);
        check("t3_cnt_eq", 32'(bus_a.cnt_eq), 32'd2);

        // 4: illegal sample restarts the run and sets the error flags
        samples(2, 1'b1, 1'b0, 1'b0);
        samples(1, 1'b1, 1'b1, 1'b0);
        check("t4_err_pulse",  32'(bus_a.err_pulse), 32'd1);
        check("t4_err_sticky", 32'(bus_a.err_sticky), 32'd1);
        check("t4_state_held", 32'(bus_a.state), 32'd2);
        samples(2, 1'b1, 1'b0, 1'b0);
        check("t4_err_pulse_off", 32'(bus_a.err_pulse), 32'd0);
        check("t4_sticky_held",   32'(bus_a.err_sticky), 32'd1);
        check("t4_run_restart",   32'(bus_a.state), 32'd2);
        samples(2, 1'b1, 1'b0, 1'b0);
        check("t4_requal",  32'(bus_a.state), 32'd1);
        check("t4_cnt_lt",  32'(bus_a.cnt_lt), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_clear_sticky", 32'(bus_a.err_sticky), 32'd0);
        check("t4_clear_cnts",   32'(bus_a.cnt_lt) | 32'(bus_a.cnt_eq) | 32'(bus_a.cnt_gt), 32'd0);
        check("t4_clear_state",  32'(bus_a.state), 32'd1);
        // All-zero flags are illegal too; clear in the same cycle keeps sticky low
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_err_clr_pulse",  32'(bus_a.err_pulse), 32'd1);
        check("t4_err_clr_sticky", 32'(bus_a.err_sticky), 32'd0);

        // 5: five LOW/HIGH toggles; CNT_W=2 saturates at 3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            samples(4, 1'b1, 1'b0, 1'b0);
            samples(4, 1'b0, 1'b0, 1'b1);
        end
        check("t5_b_cnt_lt", 32'(bus_b.cnt_lt), 32'd3);
        check("t5_b_cnt_gt", 32'(bus_b.cnt_gt), 32'd3);
        check("t5_a_cnt_lt", 32'(bus_a.cnt_lt), 32'd5);
        check("t5_a_cnt_gt", 32'(bus_a.cnt_gt), 32'd5);
        check("t5_b_state",  32'(bus_b.state), 32'd3);
        samples(3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t5_clr_state",  32'(bus_b.state), 32'd1);
        check("t5_clr_change", 32'(bus_b.change_pulse), 32'd1);
        check("t5_clr_b_cnts", 32'(bus_b.cnt_lt) | 32'(bus_b.cnt_gt), 32'd0);
        check("t5_clr_a_cnt_lt", 32'(bus_a.cnt_lt), 32'd0);

        // 6: reset mid-run discards the partial run
        do_reset();
        samples(3, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        samples(1, 1'b0, 1'b0, 1'b1);
        check("t6_state",  32'(bus_a.state), 32'd0);
        check("t6_svalid", 32'(bus_a.state_valid), 32'd0);
        check("t6_cnts",   32'(bus_a.cnt_lt) | 32'(bus_a.cnt_eq) | 32'(bus_a.cnt_gt), 32'd0);
        samples(3, 1'b0, 1'b0, 1'b1);
        check("t6_high",   32'(bus_a.state), 32'd3);
        check("t6_cnt_gt", 32'(bus_a.cnt_gt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
